// File: rtl/seq_detector_param_if.sv
// Bundles the serial-data, control and status signals of seq_detector_param.
// Build option: define SEQ_DET_MASK_EN to add the mask_in signal.
interface seq_detector_param_if #(
    parameter int unsigned PAT_W = 3,
    parameter int unsigned CNT_W = 8
) ();
    logic             in;
    logic             in_valid;
    logic             overlap;
    logic             load;
    logic [PAT_W-1:0] pat_in;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] mask_in;
`endif
    logic             clr_cnt;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;

    // Upstream side: drives data/control, observes detector status.
    modport master (
`ifdef SEQ_DET_MASK_EN
        output mask_in,
`endif
        output in, in_valid, overlap, load, pat_in, clr_cnt,
        input  match, match_cnt, busy
    );

    // Detector side.
    modport slave (
`ifdef SEQ_DET_MASK_EN
        input  mask_in,
`endif
        input  in, in_valid, overlap, load, pat_in, clr_cnt,
        output match, match_cnt, busy
    );
endinterface

// File: rtl/seq_detector_param.sv
// Moore serial sequence detector: compares the last PAT_W valid bits against a
// loadable pattern, with overlapping/non-overlapping modes and a saturating
// match counter. match and busy are registered decodes of the next state.
// Build option: define SEQ_DET_MASK_EN to add a per-bit don't-care mask.
module seq_detector_param #(
    parameter int unsigned PAT_W   = 3,
    parameter int unsigned CNT_W   = 8,
    parameter logic [31:0] RST_PAT = 32'b101
) (
    input logic                clk,
    input logic                rst,
    seq_detector_param_if.slave bus
);
    localparam int unsigned        FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [PAT_W-1:0]   PAT_INIT = RST_PAT[PAT_W-1:0];

    typedef enum logic [1:0] {StFill, StArmed, StHit} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               hit_ovl_q, hit_ovl_d;   // overlap mode captured with the completing bit
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q;
    logic               busy_q;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]   mask_q, mask_d;
`endif

    logic [PAT_W-1:0]   hist_base;
    logic [FILL_W-1:0]  fill_base;
    logic [PAT_W-1:0]   hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               cmp_eq;

    // Next-state: restart after a non-overlapping hit, then shift/count/compare.
    always_comb begin
        pat_d     = pat_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        state_d   = state_q;
        hit_ovl_d = hit_ovl_q;
        cnt_d     = cnt_q;
`ifdef SEQ_DET_MASK_EN
        mask_d    = mask_q;
`endif

        // Leaving a non-overlapping hit starts from empty, so a bit arriving in
        // the hit cycle becomes the first fill bit.
        hist_base = hist_q;
        fill_base = fill_q;
        if (state_q == StHit && !hit_ovl_q) begin
            hist_base = '0;
            fill_base = '0;
        end

        hist_shift = {hist_base[PAT_W-2:0], bus.in};
        fill_inc   = (fill_base == FILL_MAX) ? fill_base : fill_base + FILL_W'(1);
`ifdef SEQ_DET_MASK_EN
        cmp_eq     = ((hist_shift ^ pat_q) & mask_q) == '0;
`else
        cmp_eq     = (hist_shift == pat_q);
`endif

        if (bus.load) begin
            // Load has priority; a coincident data bit is dropped.
            pat_d   = bus.pat_in;
`ifdef SEQ_DET_MASK_EN
            mask_d  = bus.mask_in;
`endif
            hist_d  = '0;
            fill_d  = '0;
            state_d = StFill;
        end else if (bus.in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (fill_inc == FILL_MAX && cmp_eq) begin
                state_d   = StHit;
                hit_ovl_d = bus.overlap;
            end else begin
                state_d = (fill_inc == FILL_MAX) ? StArmed : StFill;
            end
        end else begin
            hist_d  = hist_base;
            fill_d  = fill_base;
            state_d = (fill_base == FILL_MAX) ? StArmed : StFill;
        end

        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (state_d == StHit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and registered Moore outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFill;
            pat_q     <= PAT_INIT;
            hist_q    <= '0;
            fill_q    <= '0;
            hit_ovl_q <= 1'b0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            hit_ovl_q <= hit_ovl_d;
            cnt_q     <= cnt_d;
            match_q   <= (state_d == StHit);
            busy_q    <= (state_d == StArmed);
`ifdef SEQ_DET_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign bus.match     = match_q;
    assign bus.busy      = busy_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a vector table plus hand-written
// sequences for saturation, clear-vs-hit and asynchronous reset.
module tb_seq_detector_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_W(3), .CNT_W(8)) d_if ();
    seq_detector_param_if #(.PAT_W(3), .CNT_W(2)) s_if ();

    seq_detector_param #(.PAT_W(3), .CNT_W(8), .RST_PAT(32'b101)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (d_if.slave)
    );

    seq_detector_param #(.PAT_W(3), .CNT_W(2), .RST_PAT(32'b111)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    typedef struct {
        string      name;
        logic       vld;
        logic       bit_in;
        logic       ovl;
        logic       ld;
        logic [2:0] pat;
        logic       clr;
        logic [2:0] msk;
        logic       m;
        logic       bs;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(string nm, logic vld, logic b, logic ovl, logic ld,
                                logic [2:0] pat, logic clr, logic [2:0] msk,
                                logic m, logic bs, logic [7:0] c);
        vec_t v;
        v.name = nm; v.vld = vld; v.bit_in = b; v.ovl = ovl; v.ld = ld; v.pat = pat;
        v.clr = clr; v.msk = msk; v.m = m; v.bs = bs; v.cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        d_if.in_valid = v.vld;
        d_if.in       = v.bit_in;
        d_if.overlap  = v.ovl;
        d_if.load     = v.ld;
        d_if.pat_in   = v.pat;
        d_if.clr_cnt  = v.clr;
`ifdef SEQ_DET_MASK_EN
        d_if.mask_in  = v.msk;
`endif
        @(posedge clk);
        #1;
        check({v.name, ".match"}, 32'(d_if.match), 32'(v.m));
        check({v.name, ".busy"},  32'(d_if.busy),  32'(v.bs));
        check({v.name, ".cnt"},   32'(d_if.match_cnt), 32'(v.cnt));
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();
        d_if.in_valid = 1'b0;
        d_if.load     = 1'b0;
        d_if.clr_cnt  = 1'b0;
    endtask

    logic [1:0] sat_exp [8];

    initial begin
        d_if.in = 0; d_if.in_valid = 0; d_if.overlap = 0; d_if.load = 0;
        d_if.pat_in = '0; d_if.clr_cnt = 0;
        s_if.in = 0; s_if.in_valid = 0; s_if.overlap = 0; s_if.load = 0;
        s_if.pat_in = '0; s_if.clr_cnt = 0;
`ifdef SEQ_DET_MASK_EN
        d_if.mask_in = '1;
        s_if.mask_in = '1;
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst.match", 32'(d_if.match), 0);
        check("rst.busy",  32'(d_if.busy), 0);
        check("rst.cnt",   32'(d_if.match_cnt), 0);
        check("rst.sat_cnt", 32'(s_if.match_cnt), 0);
        rst = 1'b1;

        //            name      vld in ovl ld pat     clr msk     m  bs cnt
        // Overlapping detection of 101 on 1,0,1,0,1.
        vecs.push_back(mk("ov1",  1, 1, 1, 0, 3'b000, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk("ov2",  1, 0, 1, 0, 3'b000, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk("ov3",  1, 1, 1, 0, 3'b000, 0, 3'b111, 1, 0, 1));
        vecs.push_back(mk("ov4",  1, 0, 1, 0, 3'b000, 0, 3'b111, 0, 1, 1));
        vecs.push_back(mk("ov5",  1, 1, 1, 0, 3'b000, 0, 3'b111, 1, 0, 2));
        vecs.push_back(mk("ov6",  0, 0, 1, 0, 3'b000, 0, 3'b111, 0, 1, 2));
        vecs.push_back(mk("ov7",  0, 0, 1, 0, 3'b000, 0, 3'b111, 0, 1, 2));
        // Non-overlapping: reload 101 and clear count, same stream.
        vecs.push_back(mk("nl0",  0, 0, 0, 1, 3'b101, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk("nl1",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk("nl2",  1, 0, 0, 0, 3'b000, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk("nl3",  1, 1, 0, 0, 3'b000, 0, 3'b111, 1, 0, 1));
        vecs.push_back(mk("nl4",  1, 0, 0, 0, 3'b000, 0, 3'b111, 0, 0, 1));
        vecs.push_back(mk("nl5",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 1));
        vecs.push_back(mk("nl6",  0, 0, 0, 0, 3'b000, 0, 3'b111, 0, 0, 1));
        vecs.push_back(mk("nl7",  1, 0, 0, 0, 3'b000, 0, 3'b111, 0, 1, 1));
        // Pattern 110 with valid gaps.
        vecs.push_back(mk("gp0",  0, 0, 0, 1, 3'b110, 0, 3'b111, 0, 0, 1));
        vecs.push_back(mk("gp1",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 1));
        vecs.push_back(mk("gp2",  0, 0, 0, 0, 3'b000, 0, 3'b111, 0, 0, 1));
        vecs.push_back(mk("gp3",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 1));
        vecs.push_back(mk("gp4",  0, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 1));
        vecs.push_back(mk("gp5",  1, 0, 0, 0, 3'b000, 0, 3'b111, 1, 0, 2));
        vecs.push_back(mk("gp6",  0, 0, 0, 0, 3'b000, 0, 3'b111, 0, 0, 2));
        // Load coinciding with the completing bit suppresses the hit.
        vecs.push_back(mk("lc1",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 2));
        vecs.push_back(mk("lc2",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 2));
        vecs.push_back(mk("lc3",  1, 0, 0, 1, 3'b110, 0, 3'b111, 0, 0, 2));
        vecs.push_back(mk("lc4",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 2));
        vecs.push_back(mk("lc5",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 2));
        vecs.push_back(mk("lc6",  1, 0, 0, 0, 3'b000, 0, 3'b111, 1, 0, 3));
        // Get into ARMED with a nonzero count before the reset test.
        vecs.push_back(mk("pr0",  0, 0, 1, 1, 3'b101, 0, 3'b111, 0, 0, 3));
        vecs.push_back(mk("pr1",  1, 1, 1, 0, 3'b000, 0, 3'b111, 0, 0, 3));
        vecs.push_back(mk("pr2",  1, 0, 1, 0, 3'b000, 0, 3'b111, 0, 0, 3));
        vecs.push_back(mk("pr3",  1, 1, 1, 0, 3'b000, 0, 3'b111, 1, 0, 4));
        vecs.push_back(mk("pr4",  1, 0, 1, 0, 3'b000, 0, 3'b111, 0, 1, 4));
        run_vecs();

        // Asynchronous reset mid-cycle: outputs drop before any clock edge.
        #3;
        rst = 1'b0;
        #1;
        check("arst.match", 32'(d_if.match), 0);
        check("arst.busy",  32'(d_if.busy), 0);
        check("arst.cnt",   32'(d_if.match_cnt), 0);
        @(posedge clk);
        #1;
        check("arst_hold.cnt", 32'(d_if.match_cnt), 0);
        rst = 1'b1;
        // History cleared: a lone 1 cannot complete 101; a full fresh 101 can.
        vecs.push_back(mk("ar1",  1, 1, 1, 0, 3'b000, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk("ar2",  1, 0, 1, 0, 3'b000, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk("ar3",  1, 1, 1, 0, 3'b000, 0, 3'b111, 1, 0, 1));
        vecs.push_back(mk("ar4",  0, 0, 1, 0, 3'b000, 0, 3'b111, 0, 1, 1));
        run_vecs();

        // Saturation on the 2-bit counter instance, pattern 111, eight 1s.
        sat_exp = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        s_if.overlap  = 1'b1;
        s_if.in       = 1'b1;
        s_if.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d.match", k + 1), 32'(s_if.match), (k >= 2) ? 1 : 0);
            check($sformatf("sat%0d.cnt", k + 1), 32'(s_if.match_cnt), 32'(sat_exp[k]));
        end
        // Clear coincident with another hit: clear wins.
        s_if.clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        check("satclr.match", 32'(s_if.match), 1);
        check("satclr.cnt",   32'(s_if.match_cnt), 0);
        s_if.clr_cnt  = 1'b0;
        s_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("satidle.match", 32'(s_if.match), 0);
        check("satidle.busy",  32'(s_if.busy), 1);
        check("satidle.cnt",   32'(s_if.match_cnt), 0);

`ifdef SEQ_DET_MASK_EN
        vecs.push_back(mk("mk0",  0, 0, 0, 1, 3'b101, 0, 3'b101, 0, 0, 1));
        vecs.push_back(mk("mk1",  1, 1, 0, 0, 3'b000, 0, 3'b101, 0, 0, 1));
        vecs.push_back(mk("mk2",  1, 1, 0, 0, 3'b000, 0, 3'b101, 0, 0, 1));
        vecs.push_back(mk("mk3",  1, 1, 0, 0, 3'b000, 0, 3'b101, 1, 0, 2));
        vecs.push_back(mk("mf0",  0, 0, 0, 1, 3'b101, 0, 3'b111, 0, 0, 2));
        vecs.push_back(mk("mf1",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 2));
        vecs.push_back(mk("mf2",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 0, 2));
        vecs.push_back(mk("mf3",  1, 1, 0, 0, 3'b000, 0, 3'b111, 0, 1, 2));
        vecs.push_back(mk("mz0",  0, 0, 1, 1, 3'b101, 0, 3'b000, 0, 0, 2));
        vecs.push_back(mk("mz1",  1, 0, 1, 0, 3'b000, 0, 3'b000, 0, 0, 2));
        vecs.push_back(mk("mz2",  1, 0, 1, 0, 3'b000, 0, 3'b000, 0, 0, 2));
        vecs.push_back(mk("mz3",  1, 0, 1, 0, 3'b000, 0, 3'b000, 1, 0, 3));
        vecs.push_back(mk("mz4",  1, 0, 1, 0, 3'b000, 0, 3'b000, 1, 0, 4));
        run_vecs();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
